pad_port_responder: RTL and testbench
=====================================

Name: pad_port_responder

Overview:
- CPU-side reader for the hand-controller codes produced by the pad encoder.
- Implements the AY-3-8910-style I/O window the Aquarius uses to read its two controllers:
  - address latch at port 0xF7
  - data port at 0xF6
  - register 14 returns pad0, register 15 returns pad1.
- Sits between the Z80 I/O decode and the pad encoder outputs.
- Also holds AY registers 0-13 as a masked shadow file so software readback works.

Parameters:
- ADDR_PORT, 8'hF7, I/O address of the register-select latch.
- DATA_PORT, 8'hF6, I/O address of the data register.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_wr  in  1  single-cycle I/O write strobe.
- io_rd  in  1  single-cycle I/O read strobe.
- io_addr  in  8  I/O port address, qualified by io_wr/io_rd.
- io_din  in  8  write data.
- io_dout  out  8  registered read data.
- io_dout_valid  out  1  one-cycle pulse; io_dout holds a read result.
- pad0_in  in  8  active-low controller 0 code (0xFF = idle).
- pad1_in  in  8  active-low controller 1 code.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All flops clear immediately on reset assertion, independent of clk.
- Reset values:
  - sel = 0; regs 0-13 = 0x00; port latches A/B = 0xFF.
  - io_dout = 0xFF; io_dout_valid = 0; sync stages = 0xFF.
- Select write: io_wr with io_addr == ADDR_PORT sets sel <= io_din[3:0]. io_din[7:4] is ignored.
- Data write: io_wr with io_addr == DATA_PORT writes io_din to reg[sel].
  - sel 14 writes latch A; sel 15 writes latch B.
  - Stored values are masked per the read-mask table below.
- Read: io_rd with io_addr == DATA_PORT gives:
  - io_dout updated on the next rising edge;
  - io_dout_valid high for exactly that one cycle (latency 1).
- Reads at any other address: io_dout unchanged, io_dout_valid stays 0.
- Read-mask table (unimplemented bits read 0):
  - regs 1, 3, 5, 13: 0x0F
  - reg 6 and regs 8-10: 0x1F
  - all others: 0xFF
- sel 14 read: if reg7 bit6 = 1 (port A output), return latch A; else return the pad0 sample.
- sel 15 read: same rule with reg7 bit7, latch B and the pad1 sample.
- Pad samples: taken at the read strobe cycle and passed through unmodified. No decoding or inversion.
- Simultaneous events:
  - io_rd and io_wr at DATA_PORT in the same cycle: read returns the pre-write value; write completes in that same edge.
  - Select write and data read in the same cycle: read uses the old sel.
- Back-to-back reads on consecutive cycles: each produces its own valid pulse. No stalls, no ready signal.
- Reset mid-read: the pending valid pulse is cancelled.

Optional Feature:
- Macro: PAD_PORT_SYNC_EN.
- Defined:
  - pad0_in/pad1_in pass through a 2-flop synchronizer (reset 0xFF) before sampling.
  - An input change becomes readable 2 cycles later.
- Undefined:
  - Pad inputs are sampled directly.
  - A change is visible to a read strobe in the same cycle.

Decomposition:
- Package pad_port_pkg holds:
  - port address defaults;
  - register indices (REG_MIXER = 7, REG_PORTA = 14, REG_PORTB = 15);
  - the 16-entry read-mask constant array.
- One sub-module, pad_sync8: 8-bit 2-flop synchronizer with asynchronous reset to 0xFF. Instantiated twice, only under PAD_PORT_SYNC_EN.

Test Plan:
- Reset, then pad0_in = 0xFD; write 0x0E to 0xF7; read 0xF6 -> io_dout = 0xFD, io_dout_valid high exactly one cycle after the strobe (3 cycles under PAD_PORT_SYNC_EN if pad changed just before).
- sel 15, pad1_in = 0x5F -> read 0x5F; change pad1_in to 0xFF, read again -> 0xFF.
- Write sel 1 then data 0xFF -> read 0x0F; sel 6 data 0xFF -> 0x1F; sel 0 data 0xA5 -> 0xA5.
- reg7 = 0x40, sel 14 write 0x12, pad0_in = 0xBF -> read 0x12; reg7 = 0x00 -> read 0xBF.
- sel 2 holds 0x33; same cycle io_wr 0x44 and io_rd at 0xF6 -> io_dout 0x33; next read -> 0x44.
- Assert reset asynchronously between read strobe and clock edge -> io_dout_valid stays 0, io_dout = 0xFF, sel = 0, reg reads 0x00.

Source files
------------

// File: rtl/pad_port_pkg.sv
// Shared constants for the pad port responder: default I/O port addresses,
// AY register indices and the per-register read mask used for the shadow file.
package pad_port_pkg;

    localparam logic [7:0] DEF_ADDR_PORT = 8'hF7;
    localparam logic [7:0] DEF_DATA_PORT = 8'hF6;

    localparam logic [3:0] REG_MIXER = 4'd7;
    localparam logic [3:0] REG_PORTA = 4'd14;
    localparam logic [3:0] REG_PORTB = 4'd15;

    localparam int NUM_SHADOW_REGS = 14;

    // Per-register read mask; masked-off positions always read back as zero.
    localparam logic [7:0] READ_MASK [0:15] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F,
        8'hFF, 8'h0F, 8'h1F, 8'hFF,
        8'h1F, 8'h1F, 8'h1F, 8'hFF,
        8'hFF, 8'h0F, 8'hFF, 8'hFF
    };

endpackage

// File: rtl/pad_port_responder_if.sv
// CPU-side I/O bus seen by the pad port responder.
// master = Z80 I/O decode side, slave = responder.
interface pad_port_responder_if;

    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_addr;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       io_dout_valid;

    modport master (
        output io_wr, io_rd, io_addr, io_din,
        input  io_dout, io_dout_valid
    );

    modport slave (
        input  io_wr, io_rd, io_addr, io_din,
        output io_dout, io_dout_valid
    );

endinterface

// File: rtl/pad_port_responder_sync.sv
// pad_sync8: 8-bit two-flop synchronizer for the asynchronous controller
// inputs. Both stages reset to 0xFF so an idle (all released) pad is seen.
module pad_sync8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_d,
    output logic [7:0] o_q
);

    logic [7:0] r_meta;
    logic [7:0] r_sync;

    // Two back-to-back flops give the first stage a cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 8'hFF;
            r_sync <= 8'hFF;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pad_port_responder.sv
// pad_port_responder: AY-3-8910 style I/O window used to read the two hand
// controllers. Port ADDR_PORT latches the register select, DATA_PORT reads or
// writes the selected register. Registers 0-13 are a masked shadow file,
// 14/15 return either the output latch or the live pad code depending on the
// direction bits in the mixer register.
// Optional: define PAD_PORT_SYNC_EN to pass the pad inputs through a two-flop
// synchronizer before they are sampled.
module pad_port_responder
    import pad_port_pkg::*;
#(
    parameter logic [7:0] ADDR_PORT = DEF_ADDR_PORT,
    parameter logic [7:0] DATA_PORT = DEF_DATA_PORT
) (
    input  logic                 clk,
    input  logic                 reset,
    pad_port_responder_if.slave  bus,
    input  logic [7:0]           pad0_in,
    input  logic [7:0]           pad1_in
);

    logic [3:0] r_sel;
    logic [7:0] r_regFile [0:NUM_SHADOW_REGS-1];
    logic [7:0] r_latchA;
    logic [7:0] r_latchB;
    logic [7:0] r_dout;
    logic       r_doutValid;

    logic       w_selWrite;
    logic       w_dataWrite;
    logic       w_dataRead;
    logic [7:0] w_pad0;
    logic [7:0] w_pad1;
    logic [7:0] w_readData;

`ifdef PAD_PORT_SYNC_EN
    pad_sync8 u_sync0 (
        .clk   (clk),
        .reset (reset),
        .i_d   (pad0_in),
        .o_q   (w_pad0)
    );

    pad_sync8 u_sync1 (
        .clk   (clk),
        .reset (reset),
        .i_d   (pad1_in),
        .o_q   (w_pad1)
    );
`else
    assign w_pad0 = pad0_in;
    assign w_pad1 = pad1_in;
`endif

    assign w_selWrite  = bus.io_wr && (bus.io_addr == ADDR_PORT);
    assign w_dataWrite = bus.io_wr && (bus.io_addr == DATA_PORT);
    assign w_dataRead  = bus.io_rd && (bus.io_addr == DATA_PORT);

    // Register select latch; only the low nibble addresses a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= 4'd0;
        end else if (w_selWrite) begin
            r_sel <= bus.io_din[3:0];
        end
    end

    // Data writes land in the shadow file or the port latches, pre-masked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SHADOW_REGS; i++) begin
                r_regFile[i] <= 8'h00;
            end
            r_latchA <= 8'hFF;
            r_latchB <= 8'hFF;
        end else if (w_dataWrite) begin
            case (r_sel)
                REG_PORTA: r_latchA <= bus.io_din & READ_MASK[REG_PORTA];
                REG_PORTB: r_latchB <= bus.io_din & READ_MASK[REG_PORTB];
                default:   r_regFile[r_sel] <= bus.io_din & READ_MASK[r_sel];
            endcase
        end
    end

    // Read mux on the current select; port registers follow the mixer direction bits.
    always_comb begin
        w_readData = 8'h00;
        case (r_sel)
            REG_PORTA: w_readData = r_regFile[REG_MIXER][6] ? r_latchA : w_pad0;
            REG_PORTB: w_readData = r_regFile[REG_MIXER][7] ? r_latchB : w_pad1;
            default:   w_readData = r_regFile[r_sel];
        endcase
    end

    // Registered read port: data and a one-cycle valid pulse one edge after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout      <= 8'hFF;
            r_doutValid <= 1'b0;
        end else begin
            r_doutValid <= w_dataRead;
            if (w_dataRead) begin
                r_dout <= w_readData;
            end
        end
    end

    assign bus.io_dout       = r_dout;
    assign bus.io_dout_valid = r_doutValid;

endmodule

// File: tb/tb_pad_port_responder.sv
// Directed bench for pad_port_responder: drives I/O strobes on the falling
// edge, samples results on the following falling edge.
module tb_pad_port_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pad0In;
    logic [7:0] pad1In;

    int checks = 0;
    int failures = 0;

    pad_port_responder_if bus ();

    pad_port_responder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pad0_in (pad0In),
        .pad1_in (pad1In)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
        bus.io_wr   = 1'b1;
        bus.io_addr = addr;
        bus.io_din  = data;
        @(negedge clk);
        bus.io_wr   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] data);
        ioWrite(8'hF7, {4'h0, sel});
        ioWrite(8'hF6, data);
    endtask

    task automatic ioRead(input string tag, input logic [7:0] expData);
        bus.io_rd   = 1'b1;
        bus.io_addr = 8'hF6;
        @(negedge clk);
        bus.io_rd   = 1'b0;
        checkOutput({tag, "_valid"}, {7'd0, bus.io_dout_valid}, 8'h01);
        checkOutput({tag, "_data"}, bus.io_dout, expData);
        @(negedge clk);
        checkOutput({tag, "_vdrop"}, {7'd0, bus.io_dout_valid}, 8'h00);
    endtask

    initial begin
        reset       = 1'b1;
        pad0In      = 8'hFF;
        pad1In      = 8'hFF;
        bus.io_wr   = 1'b0;
        bus.io_rd   = 1'b0;
        bus.io_addr = 8'h00;
        bus.io_din  = 8'h00;
        idle(2);
        checkOutput("rst_dout", bus.io_dout, 8'hFF);
        checkOutput("rst_valid", {7'd0, bus.io_dout_valid}, 8'h00);
        reset = 1'b0;
        idle(1);

        $display("[TB] pad reads");
        pad0In = 8'hFD;
        idle(3);
        ioWrite(8'hF7, 8'h0E);
        ioRead("pad0", 8'hFD);
        ioWrite(8'hF7, 8'h0F);
        pad1In = 8'h5F;
        idle(3);
        ioRead("pad1_a", 8'h5F);
        pad1In = 8'hFF;
        idle(3);
        ioRead("pad1_b", 8'hFF);

        $display("[TB] shadow masks");
        applyStimulus(4'd1, 8'hFF);
        ioRead("mask_r1", 8'h0F);
        applyStimulus(4'd6, 8'hFF);
        ioRead("mask_r6", 8'h1F);
        applyStimulus(4'd0, 8'hA5);
        ioRead("mask_r0", 8'hA5);
        applyStimulus(4'd13, 8'hFF);
        ioRead("mask_r13", 8'h0F);
        applyStimulus(4'd9, 8'hEE);
        ioRead("mask_r9", 8'h0E);
        ioWrite(8'hF7, 8'hF4);
        ioWrite(8'hF6, 8'h5A);
        ioRead("sel_hi_ignored", 8'h5A);

        $display("[TB] port direction");
        applyStimulus(4'd7, 8'h40);
        applyStimulus(4'd14, 8'h12);
        pad0In = 8'hBF;
        idle(3);
        ioRead("portA_out", 8'h12);
        applyStimulus(4'd7, 8'h00);
        ioWrite(8'hF7, 8'h0E);
        ioRead("portA_in", 8'hBF);
        applyStimulus(4'd7, 8'h80);
        applyStimulus(4'd15, 8'h77);
        ioRead("portB_out", 8'h77);

        $display("[TB] simultaneous read/write");
        applyStimulus(4'd2, 8'h33);
        bus.io_wr   = 1'b1;
        bus.io_rd   = 1'b1;
        bus.io_addr = 8'hF6;
        bus.io_din  = 8'h44;
        @(negedge clk);
        bus.io_wr = 1'b0;
        bus.io_rd = 1'b0;
        checkOutput("rw_same_valid", {7'd0, bus.io_dout_valid}, 8'h01);
        checkOutput("rw_same_data", bus.io_dout, 8'h33);
        idle(1);
        ioRead("rw_after", 8'h44);

        $display("[TB] back-to-back and foreign address");
        bus.io_rd   = 1'b1;
        bus.io_addr = 8'hF6;
        @(negedge clk);
        checkOutput("b2b_valid0", {7'd0, bus.io_dout_valid}, 8'h01);
        @(negedge clk);
        checkOutput("b2b_valid1", {7'd0, bus.io_dout_valid}, 8'h01);
        checkOutput("b2b_data1", bus.io_dout, 8'h44);
        bus.io_addr = 8'h10;
        @(negedge clk);
        bus.io_rd = 1'b0;
        checkOutput("foreign_valid", {7'd0, bus.io_dout_valid}, 8'h00);
        checkOutput("foreign_data", bus.io_dout, 8'h44);

        $display("[TB] reset mid-read");
        bus.io_rd   = 1'b1;
        bus.io_addr = 8'hF6;
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_dout", bus.io_dout, 8'hFF);
        checkOutput("arst_valid", {7'd0, bus.io_dout_valid}, 8'h00);
        @(negedge clk);
        bus.io_rd = 1'b0;
        checkOutput("arst_edge_valid", {7'd0, bus.io_dout_valid}, 8'h00);
        checkOutput("arst_edge_dout", bus.io_dout, 8'hFF);
        reset = 1'b0;
        idle(1);
        ioRead("arst_reg0", 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
